// File: rtl/generic_sram.sv
`default_nettype none
// ============================================================================
// Module   : generic_sram
// Brief    : True dual-port synchronous SRAM, read-first, port 1 wins on
//            same-address write collisions.
// Revision : 1.0 - initial release
// ============================================================================
module generic_sram #(
    parameter int abits = 11,
    parameter int dbits = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [abits-1:0] a0,
    input  logic [dbits-1:0] d0,
    input  logic             we0,
    output logic [dbits-1:0] q0,
    input  logic [abits-1:0] a1,
    input  logic [dbits-1:0] d1,
    input  logic             we1,
    output logic [dbits-1:0] q1
);

    localparam int c_DEPTH = 2 ** abits;

    logic [dbits-1:0] r_mem [0:c_DEPTH-1];
    logic [dbits-1:0] r_q0;
    logic [dbits-1:0] r_q1;

    // Reads sample the array before this edge's writes land (read-first);
    // the port 1 write is issued last so it takes precedence on a collision.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_q0 <= '0;
            r_q1 <= '0;
        end else begin
            r_q0 <= r_mem[a0];
            r_q1 <= r_mem[a1];
            if (we0) begin
                r_mem[a0] <= d0;
            end
            if (we1) begin
                r_mem[a1] <= d1;
            end
        end
    end

    assign q0 = r_q0;
    assign q1 = r_q1;

endmodule
`default_nettype wire

// File: tb/tb_generic_sram.sv
`default_nettype none
// ============================================================================
// Module   : tb_generic_sram
// Brief    : Directed and randomized checks of generic_sram against a
//            sparse-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_generic_sram;

    localparam int c_AW = 11;
    localparam int c_DW = 8;

    logic            clk = 1'b0;
    logic            rstn;
    logic [c_AW-1:0] a0, a1;
    logic [c_DW-1:0] d0, d1;
    logic            we0, we1;
    logic [c_DW-1:0] q0, q1;

    int total = 0;
    int bad   = 0;

    // Reference memory: only addresses written so far exist.
    logic [c_DW-1:0] model [int];
    logic [c_DW-1:0] e0, e1;
    logic            k0, k1;

    generic_sram #(.abits(c_AW), .dbits(c_DW)) dut (
        .clk (clk),
        .rstn(rstn),
        .a0  (a0),
        .d0  (d0),
        .we0 (we0),
        .q0  (q0),
        .a1  (a1),
        .d1  (d1),
        .we1 (we1),
        .q1  (q1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [c_DW-1:0] obs,
                       input logic [c_DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, check both read ports
    // just after the edge and again mid-cycle with the inputs disturbed.
    task automatic step(input string tag, input logic r,
                        input logic w0, input logic [c_AW-1:0] ad0, input logic [c_DW-1:0] dd0,
                        input logic w1, input logic [c_AW-1:0] ad1, input logic [c_DW-1:0] dd1);
        rstn = r; we0 = w0; a0 = ad0; d0 = dd0; we1 = w1; a1 = ad1; d1 = dd1;
        @(posedge clk);
        #1;
        if (!r) begin
            e0 = '0; k0 = 1'b1;
            e1 = '0; k1 = 1'b1;
        end else begin
            k0 = model.exists(int'(ad0));
            e0 = k0 ? model[int'(ad0)] : '0;
            k1 = model.exists(int'(ad1));
            e1 = k1 ? model[int'(ad1)] : '0;
            if (w0) model[int'(ad0)] = dd0;
            if (w1) model[int'(ad1)] = dd1;
        end
        if (k0) chk({tag, ".q0"}, q0, e0);
        if (k1) chk({tag, ".q1"}, q1, e1);
        we0 = 1'b0; we1 = 1'b0;
        a0 = c_AW'($urandom); a1 = c_AW'($urandom);
        d0 = c_DW'($urandom); d1 = c_DW'($urandom);
        #4;
        if (k0) chk({tag, ".hold_q0"}, q0, e0);
        if (k1) chk({tag, ".hold_q1"}, q1, e1);
    endtask

    initial begin
        rstn = 1'b0; we0 = 1'b0; we1 = 1'b0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        #2;

        // Reset holds outputs at zero and blocks writes.
        step("rst1", 1'b0, 1'b1, 11'd5, 8'hAA, 1'b0, 11'd0, 8'h00);
        step("rst2", 1'b0, 1'b1, 11'd5, 8'hAA, 1'b0, 11'd0, 8'h00);
        step("rd5",  1'b1, 1'b0, 11'd5, 8'h00, 1'b0, 11'd5, 8'h00);
        total++;
        assert (q0 !== 8'hAA) else begin
            bad++;
            $error("FAIL rst_nowrite: observed=%h expected=not AA", q0);
        end

        // Write on port 0, read back on port 1.
        step("basic_w", 1'b1, 1'b1, 11'h010, 8'h3C, 1'b0, 11'h000, 8'h00);
        step("basic_r", 1'b1, 1'b0, 11'h000, 8'h00, 1'b0, 11'h010, 8'h00);
        chk("basic_q1", q1, 8'h3C);

        // Read-first on the same port.
        step("rf_init",  1'b1, 1'b1, 11'd7, 8'h11, 1'b0, 11'd0, 8'h00);
        step("rf_write", 1'b1, 1'b1, 11'd7, 8'h22, 1'b0, 11'd0, 8'h00);
        chk("rf_old", e0, 8'h11);
        step("rf_read",  1'b1, 1'b0, 11'd7, 8'h00, 1'b0, 11'd0, 8'h00);
        chk("rf_new", q0, 8'h22);

        // Same-address collision: port 1 wins, cross-port reads see old data.
        step("col_w",  1'b1, 1'b1, 11'h7FF, 8'h01, 1'b1, 11'h7FF, 8'h02);
        step("col_r",  1'b1, 1'b0, 11'h7FF, 8'h00, 1'b0, 11'h7FF, 8'h00);
        chk("col_q0", q0, 8'h02);
        chk("col_q1", q1, 8'h02);

        // Independent writes in the same cycle, then crossed reads.
        step("par_w", 1'b1, 1'b1, 11'h000, 8'h55, 1'b1, 11'h400, 8'h66);
        step("par_r", 1'b1, 1'b0, 11'h400, 8'h00, 1'b0, 11'h000, 8'h00);
        chk("par_q0", q0, 8'h66);
        chk("par_q1", q1, 8'h55);

        // Cross-port read of a word being written by the other port.
        step("xr_w", 1'b1, 1'b1, 11'h010, 8'hC3, 1'b0, 11'h010, 8'h00);
        chk("xr_old", q1, 8'h3C);

        // Contents survive a reset pulse.
        step("per_w",   1'b1, 1'b1, 11'd3, 8'h9E, 1'b0, 11'd0, 8'h00);
        step("per_rst", 1'b0, 1'b0, 11'd3, 8'h00, 1'b0, 11'd3, 8'h00);
        chk("per_rstq", q0, 8'h00);
        step("per_r",   1'b1, 1'b0, 11'd3, 8'h00, 1'b0, 11'd3, 8'h00);
        chk("per_q0", q0, 8'h9E);

        // Randomized traffic on a small window to force frequent collisions.
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 19) != 0),
                 1'($urandom), 11'($urandom_range(0, 15)), 8'($urandom),
                 1'($urandom), 11'($urandom_range(0, 15)), 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/generic_sram.md
GENERIC_SRAM -- requirements
Module: generic_sram

Interface
REQ-001 SHALL have parameter abits, default 11, meaning address width; depth = 2**abits words.
REQ-002 SHALL have parameter dbits, default 8, meaning data word width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port a0  input  abits  port 0 address.
REQ-006 SHALL have port d0  input  dbits  port 0 write data.
REQ-007 SHALL have port we0  input  1  port 0 write enable, active-high.
REQ-008 SHALL have port q0  output  dbits  port 0 registered read data.
REQ-009 SHALL have port a1  input  abits  port 1 address.
REQ-010 SHALL have port d1  input  dbits  port 1 write data.
REQ-011 SHALL have port we1  input  1  port 1 write enable, active-high.
REQ-012 SHALL have port q1  output  dbits  port 1 registered read data.

Function
REQ-013 SHALL be a true dual-port memory of 2**abits x dbits words; both ports read and write the whole array independently.
REQ-014 SHALL have no separate chip enable; each port performs a read on every non-reset cycle.
REQ-015 Writes SHALL occur at the rising edge of clk when weN=1: mem[aN] <= dN.
REQ-016 Reads SHALL be synchronous with 1-cycle latency: qN after edge k = contents of mem[aN sampled at edge k] before any write at edge k.
REQ-017 qN SHALL hold its value between edges; combinational paths from inputs to outputs are forbidden.
REQ-018 Same-port read-during-write SHALL be read-first: qN returns the old word, and the new word is visible from the next access.
REQ-019 Cross-port read of an address written by the other port in the same cycle SHALL return the old word.
REQ-020 Both ports writing the same address in the same cycle SHALL store d1 (port 1 wins); both qN return the old word.
REQ-021 Writes to different addresses in the same cycle SHALL both take effect.
REQ-022 Every abits-wide address SHALL be valid; no wrap-around or out-of-range handling is needed.
REQ-023 Memory contents SHALL be undefined (X in simulation) until written.

Reset
REQ-024 When rstn=0 at a rising edge, q0 and q1 SHALL be driven to 0 at that edge.
REQ-025 While rstn=0, writes SHALL be suppressed on both ports regardless of we0/we1.
REQ-026 Memory array contents SHALL NOT be cleared by reset; words written before reset persist.
REQ-027 On the first edge with rstn=1, normal read/write operation SHALL resume, with qN valid one cycle later.

Verification
REQ-028 Reset: rstn=0 for 2 cycles with we0=1 a0=5 d0=0xAA -> q0=q1=0, and mem[5] stays unwritten (a later read of 5 is not 0xAA).
REQ-029 Basic: port 0 writes 0x3C to address 0x10; next cycle port 1 reads 0x10 -> q1=0x3C one cycle after the address is applied.
REQ-030 Read-first: mem[7]=0x11; port 0 writes 0x22 to 7 -> q0=0x11 that cycle; a read of 7 on the next cycle -> q0=0x22.
REQ-031 Collision: both ports write address 0x7FF, d0=0x01 and d1=0x02 -> a later read on either port returns 0x02.
REQ-032 Parallel: port 0 writes 0x55 to 0, port 1 writes 0x66 to 0x400 in the same cycle, then crossed reads -> q0=0x66 and q1=0x55.
REQ-033 Persistence: write 0x9E to 3, pulse rstn low for 1 cycle, then read 3 -> q0 reads 0 during reset and 0x9E after.
